// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared constants and types for the MCS8 fetch stage
// Purpose: address/data widths, fetch FSM state encoding, opcode-group
//          selectors and instruction length codes used by cpu_fetch and cpu_ilen.
// Ports:   none (package)
package cpu_fetch_pkg;

    localparam int FETCH_ADDR_W = 14;
    localparam int FETCH_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_B2   = 3'd2,
        ST_B3   = 3'd3,
        ST_OUT  = 3'd4
    } fetch_state_e;

    // Instruction length codes as presented on D_LEN_O
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // Opcode group selectors on op[7:6]
    localparam logic [1:0] GRP_IMM = 2'b00;
    localparam logic [1:0] GRP_JMP = 2'b01;

endpackage

// File: rtl/cpu_ilen.sv
// rtl/cpu_ilen.sv - combinational opcode to instruction length decode
// Purpose: derive the byte count of an MCS8 instruction from its opcode.
// Ports:   op_i  [7:0] opcode byte
//          len_o [1:0] instruction length (LEN_1/LEN_2/LEN_3)
module cpu_ilen
    import cpu_fetch_pkg::*;
(
    input  logic [FETCH_DATA_W-1:0] op_i,
    output logic [1:0]              len_o
);

    always_comb begin
        len_o = LEN_1;
        // 00xxx1x0: ALU-immediate (xx100) and MVI (xx110) carry one data byte
        if (op_i[7:6] == GRP_IMM && op_i[2] == 1'b1 && op_i[0] == 1'b0) begin
            len_o = LEN_2;
        // 01xxxxx0: JMP/CAL and their conditional forms carry a 14-bit address
        end else if (op_i[7:6] == GRP_JMP && op_i[0] == 1'b0) begin
            len_o = LEN_3;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - MCS8 instruction fetch stage
// Purpose: fetches 1..3 bytes at PC_I over a req/ack byte bus, pulses PC_INC_O
//          per byte, and hands a complete instruction to decode (valid/ready).
// Ports:   CLK_I, RST_I (async, active high)
//          PC_I, PC_INC_O, REDIRECT_I            - cpu_pc interface
//          MEM_REQ_O, MEM_ADDR_O, MEM_ACK_I, MEM_DATA_I - byte read bus
//          D_VALID_O, D_READY_I, D_OPCODE_O, D_IMM_LO_O, D_IMM_HI_O,
//          D_LEN_O, D_PC_O                       - decode interface
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [ADDR_W-1:0] PC_I,
    output logic              PC_INC_O,
    input  logic              REDIRECT_I,
    output logic              MEM_REQ_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    input  logic              MEM_ACK_I,
    input  logic [DATA_W-1:0] MEM_DATA_I,
    output logic              D_VALID_O,
    input  logic              D_READY_I,
    output logic [DATA_W-1:0] D_OPCODE_O,
    output logic [DATA_W-1:0] D_IMM_LO_O,
    output logic [5:0]        D_IMM_HI_O,
    output logic [1:0]        D_LEN_O,
    output logic [ADDR_W-1:0] D_PC_O
);

    fetch_state_e      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] imm_lo_q;
    logic [5:0]        imm_hi_q;
    logic [1:0]        len_q;
    logic [ADDR_W-1:0] dpc_q;
    logic [1:0]        op_len;

    cpu_ilen u_ilen (
        .op_i  (MEM_DATA_I),
        .len_o (op_len)
    );

    // An ack only counts while a request is outstanding; a redirect kills it.
    assign PC_INC_O = req_q & MEM_ACK_I & ~REDIRECT_I;

    // In the byte states req_q=0 marks the one-cycle gap in which cpu_pc
    // settles; PC_I is latched as the request address at the end of the gap.
    // In OUT, valid_q=0 plays the same role after the last byte.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            imm_lo_q <= '0;
            imm_hi_q <= '0;
            len_q    <= '0;
            dpc_q    <= '0;
        end else if (REDIRECT_I) begin
            // A transfer coinciding with the redirect has already been taken
            // by decode this cycle; everything in flight is discarded.
            state_q  <= ST_OP;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            imm_lo_q <= '0;
            imm_hi_q <= '0;
            len_q    <= '0;
            dpc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_OP;
                    req_q   <= 1'b1;
                    addr_q  <= PC_I;
                end
                ST_OP: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= PC_I;
                    end else if (MEM_ACK_I) begin
                        req_q    <= 1'b0;
                        opcode_q <= MEM_DATA_I;
                        imm_lo_q <= '0;
                        imm_hi_q <= '0;
                        len_q    <= op_len;
                        dpc_q    <= addr_q;
                        state_q  <= (op_len == LEN_1) ? ST_OUT : ST_B2;
                    end
                end
                ST_B2: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= PC_I;
                    end else if (MEM_ACK_I) begin
                        req_q    <= 1'b0;
                        imm_lo_q <= MEM_DATA_I;
                        state_q  <= (len_q == LEN_3) ? ST_B3 : ST_OUT;
                    end
                end
                ST_B3: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= PC_I;
                    end else if (MEM_ACK_I) begin
                        req_q    <= 1'b0;
                        // Upper two bits fall outside the 14-bit address space
                        imm_hi_q <= MEM_DATA_I[5:0];
                        state_q  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (D_READY_I) begin
                        // PC has already settled, so the next opcode request
                        // starts immediately after the transfer.
                        valid_q <= 1'b0;
                        state_q <= ST_OP;
                        req_q   <= 1'b1;
                        addr_q  <= PC_I;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_REQ_O  = req_q;
    assign MEM_ADDR_O = addr_q;
    assign D_VALID_O  = valid_q;
    assign D_OPCODE_O = opcode_q;
    assign D_IMM_LO_O = imm_lo_q;
    assign D_IMM_HI_O = imm_hi_q;
    assign D_LEN_O    = len_q;
    assign D_PC_O     = dpc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - directed self-checking bench for cpu_fetch
module tb_cpu_fetch;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [13:0] PC_I;
    logic        PC_INC_O;
    logic        REDIRECT_I = 1'b0;
    logic        MEM_REQ_O;
    logic [13:0] MEM_ADDR_O;
    logic        MEM_ACK_I;
    logic [7:0]  MEM_DATA_I;
    logic        D_VALID_O;
    logic        D_READY_I = 1'b0;
    logic [7:0]  D_OPCODE_O;
    logic [7:0]  D_IMM_LO_O;
    logic [5:0]  D_IMM_HI_O;
    logic [1:0]  D_LEN_O;
    logic [13:0] D_PC_O;

    cpu_fetch dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .PC_I       (PC_I),
        .PC_INC_O   (PC_INC_O),
        .REDIRECT_I (REDIRECT_I),
        .MEM_REQ_O  (MEM_REQ_O),
        .MEM_ADDR_O (MEM_ADDR_O),
        .MEM_ACK_I  (MEM_ACK_I),
        .MEM_DATA_I (MEM_DATA_I),
        .D_VALID_O  (D_VALID_O),
        .D_READY_I  (D_READY_I),
        .D_OPCODE_O (D_OPCODE_O),
        .D_IMM_LO_O (D_IMM_LO_O),
        .D_IMM_HI_O (D_IMM_HI_O),
        .D_LEN_O    (D_LEN_O),
        .D_PC_O     (D_PC_O)
    );

    always #5 CLK_I = ~CLK_I;

    // cpu_pc model
    logic [13:0] pc_q;
    logic [13:0] redir_pc = '0;
    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)           pc_q <= '0;
        else if (REDIRECT_I) pc_q <= redir_pc;
        else if (PC_INC_O)   pc_q <= pc_q + 14'd1;
    end
    assign PC_I = pc_q;

    // Byte memory with programmable wait states
    logic [7:0] mem [0:255];
    int         wait_cfg = 0;
    int         wcnt;
    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)                       wcnt <= 0;
        else if (!MEM_REQ_O || MEM_ACK_I) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end
    assign MEM_ACK_I  = MEM_REQ_O && (wcnt >= wait_cfg);
    assign MEM_DATA_I = mem[MEM_ADDR_O[7:0]];

    int inc_cnt  = 0;
    int xfer_cnt = 0;
    always @(posedge CLK_I) begin
        if (PC_INC_O)              inc_cnt++;
        if (D_VALID_O && D_READY_I) xfer_cnt++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK_I);
            cyc++;
        end while (!D_VALID_O && cyc < lim);
        if (!D_VALID_O) check_eq("valid_timeout", D_VALID_O, 1);
    endtask

    int cyc;
    int ib;
    int xb;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hC0;
        mem[8'h10] = 8'h0E; mem[8'h11] = 8'h55;
        mem[8'h20] = 8'h44; mem[8'h21] = 8'h34; mem[8'h22] = 8'hD2;
        mem[8'h23] = 8'h0E; mem[8'h24] = 8'h77;
        mem[8'h40] = 8'hC0;

        RST_I = 1'b1;
        repeat (2) @(negedge CLK_I);
        check_eq("rst_req",    MEM_REQ_O, 0);
        check_eq("rst_valid",  D_VALID_O, 0);
        check_eq("rst_inc",    PC_INC_O, 0);
        check_eq("rst_bufs",   {D_OPCODE_O, D_IMM_LO_O, D_IMM_HI_O, D_LEN_O, D_PC_O}, 0);
        check_eq("rst_addr",   MEM_ADDR_O, 0);

        // 1: one-byte opcode, zero wait, ready high
        D_READY_I = 1'b1;
        ib = inc_cnt;
        RST_I = 1'b0;
        wait_valid(20, cyc);
        check_eq("t1_cycles", cyc, 3);
        check_eq("t1_opcode", D_OPCODE_O, 8'hC0);
        check_eq("t1_len",    D_LEN_O, 1);
        check_eq("t1_imm",    {D_IMM_LO_O, D_IMM_HI_O}, 0);
        check_eq("t1_pc",     D_PC_O, 14'h0000);
        check_eq("t1_incs",   inc_cnt - ib, 1);

        // Redirect coincident with transfer: decode still receives the instruction
        xb = xfer_cnt;
        redir_pc = 14'h0010;
        REDIRECT_I = 1'b1;
        @(negedge CLK_I);
        REDIRECT_I = 1'b0;
        check_eq("t1_xfer",  xfer_cnt - xb, 1);
        check_eq("t1_flush", D_VALID_O, 0);

        // 2: MVI, two bytes
        ib = inc_cnt;
        wait_valid(30, cyc);
        check_eq("t2_opcode", D_OPCODE_O, 8'h0E);
        check_eq("t2_len",    D_LEN_O, 2);
        check_eq("t2_lo",     D_IMM_LO_O, 8'h55);
        check_eq("t2_hi",     D_IMM_HI_O, 0);
        check_eq("t2_pc",     D_PC_O, 14'h0010);
        check_eq("t2_incs",   inc_cnt - ib, 2);
        xb = xfer_cnt;
        redir_pc = 14'h0020;
        REDIRECT_I = 1'b1;
        @(negedge CLK_I);
        REDIRECT_I = 1'b0;
        check_eq("t2_xfer", xfer_cnt - xb, 1);

        // 3: JMP with two wait states per byte; decode stalled afterwards
        D_READY_I = 1'b0;
        wait_cfg = 2;
        ib = inc_cnt;
        wait_valid(60, cyc);
        check_eq("t3_early",  inc_cnt - ib, 3);
        check_eq("t3_opcode", D_OPCODE_O, 8'h44);
        check_eq("t3_len",    D_LEN_O, 3);
        check_eq("t3_lo",     D_IMM_LO_O, 8'h34);
        check_eq("t3_hi",     D_IMM_HI_O, 6'h12);
        check_eq("t3_pc",     D_PC_O, 14'h0020);

        // 4: backpressure for 5 cycles, no fetch, single transfer on release
        xb = xfer_cnt;
        wait_cfg = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            check_eq("t4_hold",
                     {D_VALID_O, MEM_REQ_O, D_OPCODE_O, D_IMM_LO_O, D_IMM_HI_O, D_LEN_O, D_PC_O},
                     {1'b1, 1'b0, 8'h44, 8'h34, 6'h12, 2'd3, 14'h0020});
        end
        check_eq("t4_noxfer", xfer_cnt - xb, 0);
        D_READY_I = 1'b1;
        @(negedge CLK_I);
        check_eq("t4_xfer",    xfer_cnt - xb, 1);
        check_eq("t4_valid",   D_VALID_O, 0);
        check_eq("t4_nextreq", {MEM_REQ_O, MEM_ADDR_O}, {1'b1, 14'h0023});

        // 5: redirect in B2 coincident with the ack
        ib = inc_cnt;
        cyc = 0;
        while (!(MEM_REQ_O && (inc_cnt - ib) == 1) && cyc < 20) begin
            @(negedge CLK_I);
            cyc++;
        end
        check_eq("t5_b2ack", {MEM_REQ_O, MEM_ACK_I, MEM_ADDR_O}, {1'b1, 1'b1, 14'h0024});
        redir_pc = 14'h0040;
        REDIRECT_I = 1'b1;
        #1;
        check_eq("t5_noinc", PC_INC_O, 0);
        @(negedge CLK_I);
        REDIRECT_I = 1'b0;
        check_eq("t5_incs",  inc_cnt - ib, 1);
        check_eq("t5_state", {D_VALID_O, MEM_REQ_O, D_OPCODE_O}, {1'b0, 1'b0, 8'h00});
        @(negedge CLK_I);
        check_eq("t5_newreq", {MEM_REQ_O, MEM_ADDR_O}, {1'b1, 14'h0040});
        wait_valid(20, cyc);
        check_eq("t5_instr", {D_OPCODE_O, D_LEN_O, D_PC_O}, {8'hC0, 2'd1, 14'h0040});

        // 6: asynchronous reset while presenting, then mid-request
        D_READY_I = 1'b0;
        #2 RST_I = 1'b1;
        #1;
        check_eq("t6_valid_drop", {D_VALID_O, MEM_REQ_O, D_OPCODE_O}, 0);
        @(negedge CLK_I);
        wait_cfg = 3;
        RST_I = 1'b0;
        @(negedge CLK_I);
        check_eq("t6_req", {MEM_REQ_O, MEM_ADDR_O}, {1'b1, 14'h0000});
        #2 RST_I = 1'b1;
        #1;
        check_eq("t6_req_drop", MEM_REQ_O, 0);
        @(negedge CLK_I);
        wait_cfg = 0;
        D_READY_I = 1'b1;
        ib = inc_cnt;
        RST_I = 1'b0;
        wait_valid(20, cyc);
        check_eq("t6_cycles", cyc, 3);
        check_eq("t6_instr",  {D_OPCODE_O, D_LEN_O, D_PC_O}, {8'hC0, 2'd1, 14'h0000});
        check_eq("t6_incs",   inc_cnt - ib, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
